// File: rtl/bitonic_sorter.sv
// Pipelined bitonic sorting network: input register plus P_LOG*(P_LOG+1)/2 compare-exchange stages.
// Optional feature macro BITONIC_TAG_EN adds a user tag (DINTAG/DOTTAG) that travels with each batch.
module bitonic_sorter #(
    parameter int P_LOG = 4,
    parameter int DATW  = 64,
    parameter int KEYW  = 32,
    parameter int TAGW  = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
`ifdef BITONIC_TAG_EN
    input  logic [TAGW-1:0]               DINTAG,
    output logic [TAGW-1:0]               DOTTAG,
`endif
    input  logic [DATW*(1<<P_LOG)-1:0]    DIN,
    input  logic                          DINEN,
    input  logic                          DINDIR,
    output logic                          DINRDY,
    output logic [DATW*(1<<P_LOG)-1:0]    DOT,
    output logic                          DOTEN,
    output logic                          DOTDIR,
    input  logic                          DOTRDY
);
    localparam int N = 1 << P_LOG;
    localparam int S = P_LOG * (P_LOG + 1) / 2;
    localparam int BW = DATW * N;

    // Handshake: a batch transfers on a rising edge where valid && ready. DINRDY equals the
    // pipe-advance signal and never looks at DINEN; DOT/DOTEN/DOTDIR hold while DOTEN && !DOTRDY.
    logic                    w_adv;
    logic [S:0][BW-1:0]      r_data;
    logic [S:0]              r_vld;
    logic [S:0]              r_dir;
    logic [S-1:0][BW-1:0]    w_next;

    if (P_LOG < 1 || KEYW > DATW || KEYW < 1 || TAGW < 1) begin : g_param_err
        $error("bitonic_sorter: illegal parameter combination");
    end

    assign w_adv  = ~r_vld[S] | DOTRDY;
    assign DINRDY = w_adv;
    assign DOT    = r_data[S];
    assign DOTEN  = r_vld[S];
    assign DOTDIR = r_dir[S];

    // Level l sorts blocks of 2^l: first a mirrored compare, then half-cleaners of shrinking distance.
    for (genvar l = 1; l <= P_LOG; l++) begin : g_lvl
        for (genvar k = 0; k < l; k++) begin : g_stg
            localparam int ST  = l * (l - 1) / 2 + k;
            localparam int BLK = 1 << l;
            localparam int D   = 1 << (l - 1 - k);
            for (genvar i = 0; i < N; i++) begin : g_rec
                localparam int P     = i % BLK;
                localparam int PART  = (k == 0) ? (i - P + BLK - 1 - P) : (i ^ D);
                localparam bit IS_LO = (k == 0) ? (P < BLK / 2) : ((i & D) == 0);
                localparam int LO    = IS_LO ? i : PART;
                localparam int HI    = IS_LO ? PART : i;
                logic [KEYW-1:0] w_klo;
                logic [KEYW-1:0] w_khi;
                logic            w_swap;
                assign w_klo  = r_data[ST][DATW*LO +: KEYW];
                assign w_khi  = r_data[ST][DATW*HI +: KEYW];
                // Strict compare so equal keys never trade places.
                assign w_swap = r_dir[ST] ? (w_klo < w_khi) : (w_klo > w_khi);
                assign w_next[ST][DATW*i +: DATW] = w_swap ? r_data[ST][DATW*PART +: DATW]
                                                           : r_data[ST][DATW*i +: DATW];
            end
        end
    end

`ifdef BITONIC_TAG_EN
    logic [S:0][TAGW-1:0] r_tag;
    assign DOTTAG = r_tag[S];
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld <= '0;
            r_dir <= '0;
`ifdef BITONIC_TAG_EN
            r_tag <= '0;
`endif
        end else if (w_adv) begin
            r_vld       <= {r_vld[S-1:0], DINEN};
            r_dir       <= {r_dir[S-1:0], DINDIR};
            r_data[0]   <= DIN;
            r_data[S:1] <= w_next;
`ifdef BITONIC_TAG_EN
            r_tag       <= {r_tag[S-1:0], DINTAG};
`endif
        end
    end
endmodule
